// File: rtl/decode_issue_queue.sv
// decode_issue_queue: circular FIFO receiving decoded instructions from the
// decode mux. Unpacks the 64-bit operand body of the head entry into register
// fields, an immediate and flags, and presents it through a valid/ready
// handshake. Raises an early stall and records overflow (the mux cannot be
// back-pressured).
module decode_issue_queue #(
   parameter int depth                   = 8,
   parameter int addressWidth            = 64,
   parameter int opcodeSize              = 12,
   parameter int funcUnitCodeSize        = 3,
   parameter int instructionCounterWidth = 64,
   parameter int instMinIdWidth          = 7,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int regSize                 = 5,
   parameter int A                       = 2**9,
   parameter int B                       = 2**1,
   parameter int D                       = 2**5
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               enable_i,
   input  logic [24:0]                        instFormat_i,
   input  logic [opcodeSize-1:0]              opcode_i,
   input  logic [addressWidth-1:0]            address_i,
   input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
   input  logic [instructionCounterWidth-1:0] majID_i,
   input  logic [instMinIdWidth-1:0]          minID_i,
   input  logic [instMinIdWidth-1:0]          numMicroOps_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   input  logic [7:0]                         oprw_i,
   input  logic [3:0]                         opIsReg_i,
   input  logic                               modifiesCR_i,
   input  logic [63:0]                        body_i,
   output logic                               stall_o,
   output logic                               overflow_o,
   output logic                               badFormat_o,
   output logic                               valid_o,
   input  logic                               ready_i,
   output logic [24:0]                        instFormat_o,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            address_o,
   output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
   output logic [instructionCounterWidth-1:0] majID_o,
   output logic [instMinIdWidth-1:0]          minID_o,
   output logic [instMinIdWidth-1:0]          numMicroOps_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 pid_o,
   output logic [TidSize-1:0]                 tid_o,
   output logic [7:0]                         oprw_o,
   output logic [3:0]                         opIsReg_o,
   output logic                               modifiesCR_o,
   output logic [63:0]                        body_o,
   output logic [regSize-1:0]                 reg1_o,
   output logic [regSize-1:0]                 reg2_o,
   output logic [regSize-1:0]                 reg3_o,
   output logic [regSize-1:0]                 reg4_o,
   output logic [63:0]                        imm_o,
   output logic [3:0]                         flags_o
);

   localparam int          PTR_W = $clog2(depth);
   localparam int          CNT_W = PTR_W + 1;
   localparam logic [24:0] FMT_A = 25'(A);
   localparam logic [24:0] FMT_B = 25'(B);
   localparam logic [24:0] FMT_D = 25'(D);
   // MSB-first bit k of the body lives at body[63-k]
   localparam int          R1_HI = 63;
   localparam int          R2_HI = 63 - regSize;
   localparam int          R3_HI = 63 - 2 * regSize;
   localparam int          R4_HI = 63 - 3 * regSize;
   localparam int          IMM_HI = 63 - 2 * regSize;
   localparam int          FLG_HI = IMM_HI - 14;

   typedef struct packed {
      logic [24:0]                        instFormat;
      logic [opcodeSize-1:0]              opcode;
      logic [addressWidth-1:0]            address;
      logic [funcUnitCodeSize-1:0]        funcUnitType;
      logic [instructionCounterWidth-1:0] majID;
      logic [instMinIdWidth-1:0]          minID;
      logic [instMinIdWidth-1:0]          numMicroOps;
      logic                               is64Bit;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [7:0]                         oprw;
      logic [3:0]                         opIsReg;
      logic                               modifiesCR;
      logic [63:0]                        body;
   } entry_t;

   entry_t           mem [depth];
   entry_t           in_entry;
   entry_t           head_entry;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             fmt_ok;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop_full;

   assign in_entry = '{instFormat: instFormat_i, opcode: opcode_i, address: address_i,
                       funcUnitType: funcUnitType_i, majID: majID_i, minID: minID_i,
                       numMicroOps: numMicroOps_i, is64Bit: is64Bit_i, pid: pid_i,
                       tid: tid_i, oprw: oprw_i, opIsReg: opIsReg_i,
                       modifiesCR: modifiesCR_i, body: body_i};

   assign fmt_ok    = (instFormat_i == FMT_A) || (instFormat_i == FMT_B) || (instFormat_i == FMT_D);
   assign full      = (count == CNT_W'(depth));
   assign valid_o   = (count != '0);
   assign pop       = valid_o && ready_i && !flush_i;
   // A full queue still accepts a push when the head leaves in the same cycle
   assign push      = enable_i && fmt_ok && !flush_i && (!full || pop);
   assign drop_full = enable_i && fmt_ok && !flush_i && full && !pop;

   // Next occupancy; flush empties the queue regardless of push/pop
   always_comb begin
      count_next = count;
      if (flush_i) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Pointer, occupancy and status flag registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         stall_o     <= 1'b0;
         overflow_o  <= 1'b0;
         badFormat_o <= 1'b0;
      end else begin
         count       <= count_next;
         stall_o     <= (count_next >= CNT_W'(depth - 2));
         badFormat_o <= enable_i && !fmt_ok;
         if (drop_full) begin
            overflow_o <= 1'b1;
         end
         if (flush_i) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) begin
               tail <= tail + PTR_W'(1);
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
         end
      end
   end

   // Entry storage, written at the tail on an accepted push
   always_ff @(posedge clock_i) begin
      if (!reset_i && push) begin
         mem[tail] <= in_entry;
      end
   end

   assign head_entry     = mem[head];
   assign instFormat_o   = head_entry.instFormat;
   assign opcode_o       = head_entry.opcode;
   assign address_o      = head_entry.address;
   assign funcUnitType_o = head_entry.funcUnitType;
   assign majID_o        = head_entry.majID;
   assign minID_o        = head_entry.minID;
   assign numMicroOps_o  = head_entry.numMicroOps;
   assign is64Bit_o      = head_entry.is64Bit;
   assign pid_o          = head_entry.pid;
   assign tid_o          = head_entry.tid;
   assign oprw_o         = head_entry.oprw;
   assign opIsReg_o      = head_entry.opIsReg;
   assign modifiesCR_o   = head_entry.modifiesCR;
   assign body_o         = head_entry.body;

   // Unpack the head body according to its instruction format
   always_comb begin
      reg1_o  = head_entry.body[R1_HI -: regSize];
      reg2_o  = head_entry.body[R2_HI -: regSize];
      reg3_o  = '0;
      reg4_o  = '0;
      imm_o   = '0;
      flags_o = '0;
      if (head_entry.instFormat == FMT_A) begin
         reg3_o = head_entry.body[R3_HI -: regSize];
         reg4_o = head_entry.body[R4_HI -: regSize];
      end else if (head_entry.instFormat == FMT_B) begin
         imm_o   = {{50{head_entry.body[IMM_HI]}}, head_entry.body[IMM_HI -: 14]};
         flags_o = head_entry.body[FLG_HI -: 4];
      end else if (head_entry.instFormat == FMT_D) begin
         imm_o = {{32{head_entry.body[IMM_HI]}}, head_entry.body[IMM_HI -: 32]};
      end
   end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: table of single-entry unpack vectors, then
// scoreboarded multi-entry sequences for overflow, full-queue streaming,
// bad formats, flush and reset.
module tb_decode_issue_queue;

   localparam logic [24:0] FA = 25'd512;
   localparam logic [24:0] FB = 25'd2;
   localparam logic [24:0] FD = 25'd32;
   localparam logic [24:0] FX = 25'd64;

   logic        clock_i = 1'b0;
   logic        reset_i, flush_i, enable_i, ready_i;
   logic [24:0] instFormat_i;
   logic [11:0] opcode_i;
   logic [63:0] address_i;
   logic [2:0]  funcUnitType_i;
   logic [63:0] majID_i;
   logic [6:0]  minID_i, numMicroOps_i;
   logic        is64Bit_i;
   logic [19:0] pid_i;
   logic [15:0] tid_i;
   logic [7:0]  oprw_i;
   logic [3:0]  opIsReg_i;
   logic        modifiesCR_i;
   logic [63:0] body_i;
   logic        stall_o, overflow_o, badFormat_o, valid_o;
   logic [24:0] instFormat_o;
   logic [11:0] opcode_o;
   logic [63:0] address_o;
   logic [2:0]  funcUnitType_o;
   logic [63:0] majID_o;
   logic [6:0]  minID_o, numMicroOps_o;
   logic        is64Bit_o;
   logic [19:0] pid_o;
   logic [15:0] tid_o;
   logic [7:0]  oprw_o;
   logic [3:0]  opIsReg_o;
   logic        modifiesCR_o;
   logic [63:0] body_o;
   logic [4:0]  reg1_o, reg2_o, reg3_o, reg4_o;
   logic [63:0] imm_o;
   logic [3:0]  flags_o;

   always #5 clock_i = ~clock_i;

   decode_issue_queue #(.depth(8)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
      .instFormat_i(instFormat_i), .opcode_i(opcode_i), .address_i(address_i),
      .funcUnitType_i(funcUnitType_i), .majID_i(majID_i), .minID_i(minID_i),
      .numMicroOps_i(numMicroOps_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i),
      .oprw_i(oprw_i), .opIsReg_i(opIsReg_i), .modifiesCR_i(modifiesCR_i), .body_i(body_i),
      .stall_o(stall_o), .overflow_o(overflow_o), .badFormat_o(badFormat_o),
      .valid_o(valid_o), .ready_i(ready_i),
      .instFormat_o(instFormat_o), .opcode_o(opcode_o), .address_o(address_o),
      .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
      .numMicroOps_o(numMicroOps_o), .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
      .oprw_o(oprw_o), .opIsReg_o(opIsReg_o), .modifiesCR_o(modifiesCR_o), .body_o(body_o),
      .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o), .reg4_o(reg4_o),
      .imm_o(imm_o), .flags_o(flags_o)
   );

   typedef struct {
      logic [24:0] fmt;
      logic [63:0] body;
      logic [4:0]  r1, r2, r3, r4;
      logic [63:0] imm;
      logic [3:0]  flags;
   } vec_t;

   typedef struct {
      logic [63:0] maj;
      logic [11:0] opc;
      logic [4:0]  r1, r2, r3, r4;
      logic [63:0] imm;
      logic [3:0]  flags;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   logic [24:0] fmts [3] = '{FA, FB, FD};
   vec_t        vt [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // Build a body from chosen fields so the expected unpack is known up front
   task automatic drive(input logic [24:0] fmt, input logic [63:0] id, input bit expect_it);
      logic [4:0]  r1, r2, r3, r4;
      logic [13:0] i14;
      logic [31:0] i32;
      logic [3:0]  fl;
      logic [63:0] junk;
      exp_t        e;
      r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom); r4 = 5'($urandom);
      i14 = 14'($urandom); i32 = $urandom; fl = 4'($urandom);
      junk = {$urandom, $urandom};
      e.maj = id; e.opc = 12'($urandom);
      e.r1 = r1; e.r2 = r2; e.r3 = '0; e.r4 = '0; e.imm = '0; e.flags = '0;
      if (fmt == FA) begin
         body_i = {r1, r2, r3, r4, junk[43:0]};
         e.r3 = r3; e.r4 = r4;
      end else if (fmt == FB) begin
         body_i = {r1, r2, i14, fl, junk[35:0]};
         e.imm = {{50{i14[13]}}, i14};
         e.flags = fl;
      end else if (fmt == FD) begin
         body_i = {r1, r2, i32, junk[21:0]};
         e.imm = {{32{i32[31]}}, i32};
      end else begin
         body_i = junk;
      end
      instFormat_i = fmt; majID_i = id; opcode_i = e.opc;
      address_i = {$urandom, $urandom}; funcUnitType_i = 3'($urandom);
      minID_i = 7'($urandom); numMicroOps_i = 7'($urandom); is64Bit_i = 1'($urandom);
      pid_i = 20'($urandom); tid_i = 16'($urandom); oprw_i = 8'($urandom);
      opIsReg_i = 4'($urandom); modifiesCR_i = 1'($urandom);
      enable_i = 1'b1;
      if (expect_it) sb.push_back(e);
   endtask

   task automatic push(input logic [24:0] fmt, input logic [63:0] id, input bit expect_it);
      drive(fmt, id, expect_it);
      tick();
      enable_i = 1'b0;
   endtask

   // Pop everything with ready high; a bounded wait that fails if it never empties
   task automatic drain(input string name);
      ready_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock_i);
         if (!valid_o) break;
      end
      chk(name, 64'(valid_o), 64'd0);
      tick();
      ready_i = 1'b0;
   endtask

   // Scoreboard: compare the head against the oldest expectation on every pop
   always @(negedge clock_i) begin
      if (mon_en && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: got majID %0d expected no entry", majID_o);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_majID", majID_o, mon_e.maj);
            chk("sb_opcode", 64'(opcode_o), 64'(mon_e.opc));
            chk("sb_reg1", 64'(reg1_o), 64'(mon_e.r1));
            chk("sb_reg2", 64'(reg2_o), 64'(mon_e.r2));
            chk("sb_reg3", 64'(reg3_o), 64'(mon_e.r3));
            chk("sb_reg4", 64'(reg4_o), 64'(mon_e.r4));
            chk("sb_imm", imm_o, mon_e.imm);
            chk("sb_flags", 64'(flags_o), 64'(mon_e.flags));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
      instFormat_i = '0; opcode_i = '0; address_i = '0; funcUnitType_i = '0;
      majID_i = '0; minID_i = '0; numMicroOps_i = '0; is64Bit_i = 1'b0;
      pid_i = '0; tid_i = '0; oprw_i = '0; opIsReg_i = '0; modifiesCR_i = 1'b0;
      body_i = '0;

      vt[0] = '{FA, {5'd1, 5'd2, 5'd3, 5'd4, 44'h0}, 5'd1, 5'd2, 5'd3, 5'd4, 64'h0, 4'h0};
      vt[1] = '{FD, {5'd3, 5'd7, 32'hFFFF8000, 22'h0}, 5'd3, 5'd7, 5'd0, 5'd0,
                64'hFFFFFFFFFFFF8000, 4'h0};
      vt[2] = '{FB, {5'd9, 5'd17, 14'h1FFF, 4'hA, 36'h0}, 5'd9, 5'd17, 5'd0, 5'd0,
                64'h0000000000001FFF, 4'hA};
      vt[3] = '{FB, {5'd31, 5'd0, 14'h2000, 4'h5, 36'hFFFFFFFFF}, 5'd31, 5'd0, 5'd0, 5'd0,
                64'hFFFFFFFFFFFFE000, 4'h5};
      vt[4] = '{FA, {5'd31, 5'd16, 5'd8, 5'd0, 44'hFFFFFFFFFFF}, 5'd31, 5'd16, 5'd8, 5'd0,
                64'h0, 4'h0};
      vt[5] = '{FD, {5'd0, 5'd31, 32'h7FFFFFFF, 22'h3FFFFF}, 5'd0, 5'd31, 5'd0, 5'd0,
                64'h000000007FFFFFFF, 4'h0};

      // Reset values, observed while reset is still asserted
      repeat (2) @(posedge clock_i);
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_overflow", 64'(overflow_o), 64'd0);
      chk("rst_badFormat", 64'(badFormat_o), 64'd0);
      reset_i = 1'b0;
      tick();

      // Table: single push, check unpack on the next cycle, then pop it
      for (int i = 0; i < 6; i++) begin
         instFormat_i = vt[i].fmt; body_i = vt[i].body; majID_i = 64'(i);
         enable_i = 1'b1;
         @(negedge clock_i);
         chk("t_valid_same_cycle", 64'(valid_o), 64'd0);
         tick();
         enable_i = 1'b0;
         @(negedge clock_i);
         chk("t_valid", 64'(valid_o), 64'd1);
         chk("t_majID", majID_o, 64'(i));
         chk("t_reg1", 64'(reg1_o), 64'(vt[i].r1));
         chk("t_reg2", 64'(reg2_o), 64'(vt[i].r2));
         chk("t_reg3", 64'(reg3_o), 64'(vt[i].r3));
         chk("t_reg4", 64'(reg4_o), 64'(vt[i].r4));
         chk("t_imm", imm_o, vt[i].imm);
         chk("t_flags", 64'(flags_o), 64'(vt[i].flags));
         ready_i = 1'b1;
         @(negedge clock_i);
         chk("t_valid_after_pop", 64'(valid_o), 64'd0);
         ready_i = 1'b0;
         tick();
      end

      // Fill past capacity with no consumer: stall, drop, sticky overflow, order
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push(fmts[i % 3], 64'(i), 1'b1);
         if (i == 4) chk("ovf_stall_at5", 64'(stall_o), 64'd0);
      end
      chk("ovf_stall_at6", 64'(stall_o), 64'd1);
      push(FA, 64'd6, 1'b1);
      push(FB, 64'd7, 1'b1);
      chk("ovf_not_yet", 64'(overflow_o), 64'd0);
      push(FD, 64'd8, 1'b0);
      chk("ovf_set", 64'(overflow_o), 64'd1);
      tick();
      chk("ovf_sticky", 64'(overflow_o), 64'd1);
      drain("ovf_drain_empty");
      chk("ovf_sticky_after_drain", 64'(overflow_o), 64'd0 + 64'd1);
      chk("ovf_sb_empty", 64'(sb.size()), 64'd0);

      // Full queue streaming: push and pop together for 20 cycles
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("full_ovf_reset", 64'(overflow_o), 64'd0);
      for (int i = 0; i < 8; i++) push(fmts[i % 3], 64'(100 + i), 1'b1);
      chk("full_stall", 64'(stall_o), 64'd1);
      ready_i = 1'b1;
      for (int i = 0; i < 20; i++) push(fmts[i % 3], 64'(108 + i), 1'b1);
      chk("full_no_overflow", 64'(overflow_o), 64'd0);
      chk("full_still_stall", 64'(stall_o), 64'd1);
      drain("full_drain_empty");
      chk("full_sb_empty", 64'(sb.size()), 64'd0);

      // Bad format: dropped, one-cycle pulse, queued entries untouched
      push(FA, 64'd200, 1'b1);
      push(FD, 64'd201, 1'b1);
      drive(FX, 64'd999, 1'b0);
      @(negedge clock_i);
      chk("bad_not_early", 64'(badFormat_o), 64'd0);
      tick();
      enable_i = 1'b0;
      @(negedge clock_i);
      chk("bad_pulse", 64'(badFormat_o), 64'd1);
      tick();
      @(negedge clock_i);
      chk("bad_pulse_end", 64'(badFormat_o), 64'd0);
      chk("bad_no_overflow", 64'(overflow_o), 64'd0);
      tick();
      drain("bad_drain_empty");
      chk("bad_sb_empty", 64'(sb.size()), 64'd0);

      // Flush with 5 entries and a simultaneous push
      mon_en = 1'b0;
      for (int i = 0; i < 5; i++) push(FA, 64'(300 + i), 1'b0);
      chk("fl_valid_before", 64'(valid_o), 64'd1);
      drive(FA, 64'd305, 1'b0);
      flush_i = 1'b1;
      tick();
      enable_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clock_i);
      chk("fl_valid", 64'(valid_o), 64'd0);
      chk("fl_stall", 64'(stall_o), 64'd0);
      tick();
      @(negedge clock_i);
      chk("fl_push_discarded", 64'(valid_o), 64'd0);
      tick();

      // Queue usable again after flush
      mon_en = 1'b1;
      push(FB, 64'd400, 1'b1);
      drain("fl_reuse_drain");
      chk("fl_reuse_sb_empty", 64'(sb.size()), 64'd0);
      mon_en = 1'b0;

      // Flush keeps a sticky overflow
      for (int i = 0; i < 9; i++) push(FD, 64'(500 + i), 1'b0);
      chk("fl_ovf_set", 64'(overflow_o), 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fl_keeps_overflow", 64'(overflow_o), 64'd1);
      chk("fl_ovf_valid", 64'(valid_o), 64'd0);

      // Reset and flush together with a bad-format enable: reset wins
      for (int i = 0; i < 5; i++) push(FB, 64'(600 + i), 1'b0);
      drive(FX, 64'd605, 1'b0);
      flush_i = 1'b1;
      reset_i = 1'b1;
      tick();
      enable_i = 1'b0;
      flush_i = 1'b0;
      reset_i = 1'b0;
      chk("rf_valid", 64'(valid_o), 64'd0);
      chk("rf_stall", 64'(stall_o), 64'd0);
      chk("rf_overflow", 64'(overflow_o), 64'd0);
      chk("rf_badFormat", 64'(badFormat_o), 64'd0);
      tick();
      chk("rf_valid_later", 64'(valid_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
